// File: rtl/scale_arb_pkg.sv
// Shared types and fixed-point helper for the scale arbiter slice.
package scale_arb_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned LANES      = 3;
  localparam int unsigned Q_BITS_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MUL   = 2'd1,
    S_WRITE = 2'd2
  } state_e;

  // Signed Q-format multiply: full 64-bit product, arithmetic shift, wrap to 32 bits.
  function automatic logic signed [DATA_W-1:0] fx_mul(
    input logic signed [DATA_W-1:0] x,
    input logic signed [DATA_W-1:0] a,
    input int unsigned              shift
  );
    logic signed [2*DATA_W-1:0] prod;
    prod = (2*DATA_W)'(x) * (2*DATA_W)'(a);
    prod = prod >>> shift;
    return DATA_W'(prod);
  endfunction

endpackage

// File: rtl/scale_arbiter_rr_select.sv
// Combinational round-robin picker: first eligible index after rr_last wins.
module rr_select #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   rr_last,
  output logic               hit,
  output logic [IDX_W-1:0]   winner
);

  always_comb begin
    int unsigned idx;
    hit    = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(rr_last) + k) % NUM_REQ;
      if (!hit && eligible[IDX_W'(idx)]) begin
        hit    = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/scale_arbiter.sv
// Round-robin arbiter sharing one 3-lane Q-format scale datapath among NUM_REQ
// requester pipelines (FWFT input FIFO read side, output FIFO write side).
module scale_arbiter
  import scale_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned Q_BITS  = Q_BITS_DEF,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] req_x [NUM_REQ][LANES],
  input  logic signed [DATA_W-1:0] req_a [NUM_REQ],
  input  logic [NUM_REQ-1:0]       req_empty,
  output logic [NUM_REQ-1:0]       req_rd_en,
  output logic signed [DATA_W-1:0] rsp_out [LANES],
  input  logic [NUM_REQ-1:0]       rsp_full,
  output logic [NUM_REQ-1:0]       rsp_wr_en,
  output logic                     busy,
  output logic [IDX_W-1:0]         grant_idx,
  output logic [DATA_W-1:0]        done_count
);

  state_e                   state_q;
  logic                     busy_q;
  logic [IDX_W-1:0]         rr_last_q;
  logic [IDX_W-1:0]         grant_q;
  logic [DATA_W-1:0]        done_q;
  logic signed [DATA_W-1:0] a_q;
  logic signed [DATA_W-1:0] x_q   [LANES];
  logic signed [DATA_W-1:0] rsp_q [LANES];

  logic [NUM_REQ-1:0] eligible;
  logic               hit;
  logic [IDX_W-1:0]   winner;

  // A requester with a full output is never granted, so a pop never strands.
  assign eligible = ~req_empty & ~rsp_full;

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .eligible (eligible),
    .rr_last  (rr_last_q),
    .hit      (hit),
    .winner   (winner)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      rr_last_q <= IDX_W'(NUM_REQ - 1);
      grant_q   <= '0;
      done_q    <= '0;
      a_q       <= '0;
      for (int k = 0; k < LANES; k++) begin
        x_q[k]   <= '0;
        rsp_q[k] <= '0;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (hit) begin
            for (int k = 0; k < LANES; k++) x_q[k] <= req_x[winner][k];
            a_q     <= req_a[winner];
            grant_q <= winner;
            busy_q  <= 1'b1;
            state_q <= S_MUL;
          end
        end
        S_MUL: begin
          for (int k = 0; k < LANES; k++) rsp_q[k] <= fx_mul(x_q[k], a_q, Q_BITS);
          state_q <= S_WRITE;
        end
        S_WRITE: begin
          if (!rsp_full[grant_q]) begin
            rr_last_q <= grant_q;
            done_q    <= done_q + DATA_W'(1);
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // FIFO handshakes fire in the same cycle as the decision; forced low in reset.
  always_comb begin
    req_rd_en = '0;
    rsp_wr_en = '0;
    if (!reset) begin
      if (state_q == S_IDLE && hit)                 req_rd_en[winner]  = 1'b1;
      if (state_q == S_WRITE && !rsp_full[grant_q]) rsp_wr_en[grant_q] = 1'b1;
    end
  end

  assign rsp_out    = rsp_q;
  assign busy       = busy_q;
  assign grant_idx  = grant_q;
  assign done_count = done_q;

endmodule
